xillybus_rr_stream_arbiter: RTL and testbench
=============================================

// Module: xillybus_rr_stream_arbiter
// PURPOSE
//  Shares the single 32-bit host-bound Xillybus stream (user_r_read_32_*) among N_REQ
//  user-logic producers. Round-robin arbitration; bursts are bounded; a tagged header
//  word precedes each burst. A small standard-read FIFO (data one cycle after rden) sits
//  between the arbiter and the xillybus core. Runs on bus_clk next to xillybus_core.
// PARAMETERS
//  N_REQ        4    number of producers, 2..16
//  DEPTH_LOG2   2    output FIFO depth = 2**DEPTH_LOG2 words
//  MAX_BURST    256  max data words per grant, 1..65535
// PORTS
//  bus_clk               in   1          single clock for all logic
//  reset                 in   1          async, active-high
//  user_r_read_32_open   in   1          host file open
//  user_r_read_32_rden   in   1          core pops one word
//  user_r_read_32_data   out  32         popped word, valid the cycle after rden
//  user_r_read_32_empty  out  1          FIFO empty
//  user_r_read_32_eof    out  1          held 0
//  req_valid             in   N_REQ      producer i has a word
//  req_data              in   32*N_REQ   word of producer i at [32*i+31:32*i]
//  req_last              in   N_REQ      word is the last of its packet
//  req_ready             out  N_REQ      word accepted when valid&ready
// BEHAVIOUR
//  - Reset: data=0, empty=1, eof=0, req_ready=0, FIFO count=0, state=IDLE, rr_ptr=N_REQ-1, cont[]=0.
//  - FSM states IDLE, HDR, DATA. With open=0, force IDLE, flush FIFO, clear cont[], req_ready=0.
//  - IDLE: if any req_valid, pick the first i cyclically after rr_ptr; set grant=i and rr_ptr=i; go to HDR.
//  - HDR (header mode only): when FIFO not full, push the header and go to DATA.
//    Header: [31:24]=8'hA5, [23:16]=grant, [15]=cont[grant], [14:0]=0.
//  - DATA: req_ready[grant] = open & !full. All other ready bits are 0.
//    On accept, push req_data and increment burst_cnt (16 bits).
//    If req_last: cont[grant]=0, go to IDLE.
//    Else if burst_cnt reaches MAX_BURST: cont[grant]=1, go to IDLE (lets other producers in).
//    burst_cnt clears on entry to HDR/DATA.
//  - FIFO: full = (count==2**DEPTH_LOG2), computed from registered count.
//    A push while full never occurs: ready is gated.
//    Push and pop in the same cycle: count is unchanged.
//    Push and pop pointers wrap modulo the depth.
//  - Read side: on rden with !empty, user_r_read_32_data is updated at the next edge with the head word.
//    rden while empty is ignored; data holds.
//  - Latency: a word accepted at edge t is in the FIFO after t. empty deasserts in the same cycle if the FIFO was empty.
//    Header insertion costs 1 cycle per grant. Min IDLE->first data accept = 2 cycles.
//  - open falls mid-burst: the burst is truncated and un-accepted words stay with the producer.
//    On reopen, a new header is sent with cont=0.
//  - Reset asserted mid-burst: all state is returned immediately to reset values.
// CONFIGURATION
//  XLB_ARB_HDR_EN defined: header insertion and cont[] as above.
//  XLB_ARB_HDR_EN undefined: no HDR state (IDLE->DATA directly) and no header words.
//    Data words are concatenated raw. cont[] is absent. Arbitration and MAX_BURST are unchanged.
// TESTING
//  1. Single producer, 3 words 0x11,0x22,0x33 (last on 0x33), rden whenever !empty ->
//     host reads A5000000,00000011,00000022,00000033.
//  2. Producers 0 and 2 always valid, 1-word packets -> headers alternate channel 0,2,0,2.
//     Producer 1 never granted.
//  3. MAX_BURST=4, producer 1 sends 6 words with last on 6th ->
//     A5010000, w1..w4, A5018000, w5, w6.
//  4. FIFO full (rden held 0) -> req_ready=0, no data loss.
//     Release rden for 1 cycle -> exactly one accept in the following cycles.
//  5. Drop open after 2 of 5 words -> empty=1 next cycle.
//     Reopen -> new header with cont=0, then words 3..5.
//  6. Without XLB_ARB_HDR_EN, test 1 stimulus -> reads 00000011,00000022,00000033 only.

Source files
------------

// File: rtl/xillybus_rr_stream_arbiter_if.sv
// Signal bundle for the Xillybus read-stream arbiter: the host-bound read port
// (user_r_read_32_*) plus the N_REQ producer request lanes.
interface xillybus_rr_stream_arbiter_if #(
    parameter int unsigned N_REQ = 4
) ();
    logic                user_r_read_32_open;
    logic                user_r_read_32_rden;
    logic [31:0]         user_r_read_32_data;
    logic                user_r_read_32_empty;
    logic                user_r_read_32_eof;
    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_last;
    logic [N_REQ-1:0]    req_ready;

    // Arbiter side.
    modport slave (
        input  user_r_read_32_open, user_r_read_32_rden, req_valid, req_data, req_last,
        output user_r_read_32_data, user_r_read_32_empty, user_r_read_32_eof, req_ready
    );

    // Environment side: the xillybus core and the producers.
    modport master (
        output user_r_read_32_open, user_r_read_32_rden, req_valid, req_data, req_last,
        input  user_r_read_32_data, user_r_read_32_empty, user_r_read_32_eof, req_ready
    );
endinterface

// File: rtl/xillybus_rr_stream_arbiter.sv
// xillybus_rr_stream_arbiter: round-robin merge of N_REQ producer streams onto the single
// 32-bit host-bound Xillybus read stream, through a small standard-read output FIFO.
// Build option: define XLB_ARB_HDR_EN to prefix every grant with a tagged header word
// {8'hA5, channel, continuation flag, 15'b0}.
module xillybus_rr_stream_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned MAX_BURST  = 256
) (
    input  logic                        bus_clk,
    input  logic                        reset,
    xillybus_rr_stream_arbiter_if.slave bus
);
    localparam int unsigned IdxW  = $clog2(N_REQ);
    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    localparam logic [IdxW-1:0]       LastIdx     = IdxW'(N_REQ - 1);
    localparam logic [DEPTH_LOG2:0]   FullCnt     = Depth[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   CntOne      = 1;
    localparam logic [DEPTH_LOG2-1:0] PtrOne      = 1;
    localparam logic [15:0]           MaxBurstCnt = MAX_BURST[15:0];

    typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

    state_e          r_state, w_state_nxt;
    logic [IdxW-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [IdxW-1:0] r_grant, w_grant_nxt;
    logic [15:0]     r_burst_cnt, w_burst_cnt_nxt;
`ifdef XLB_ARB_HDR_EN
    logic [N_REQ-1:0] r_cont, w_cont_nxt;
`endif

    logic [31:0]           r_mem [Depth];
    logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [31:0]           r_data;

    logic            w_full, w_empty, w_push, w_pop, w_flush;
    logic [31:0]     w_push_data;
    logic [N_REQ-1:0] w_ready;
    logic            w_any_valid;
    logic [IdxW-1:0] w_pick, w_scan;
    logic [31:0]     w_words [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_words
        assign w_words[g] = bus.req_data[32*g +: 32];
    end

    assign w_full  = (r_count == FullCnt);
    assign w_empty = (r_count == '0);
    assign w_flush = !bus.user_r_read_32_open;
    assign w_pop   = bus.user_r_read_32_rden && !w_empty;

    // Round-robin pick: first valid producer cyclically after rr_ptr. Scanning from the far
    // end lets the nearest candidate overwrite the others.
    always_comb begin
        w_any_valid = 1'b0;
        w_pick      = r_rr_ptr;
        w_scan      = r_rr_ptr;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            w_scan = IdxW'((int'(r_rr_ptr) + k) % int'(N_REQ));
            if (bus.req_valid[w_scan]) begin
                w_any_valid = 1'b1;
                w_pick      = w_scan;
            end
        end
    end

    // Grant FSM next state, producer ready and FIFO push.
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_grant_nxt     = r_grant;
        w_burst_cnt_nxt = r_burst_cnt;
`ifdef XLB_ARB_HDR_EN
        w_cont_nxt      = r_cont;
`endif
        w_push          = 1'b0;
        w_push_data     = w_words[r_grant];
        w_ready         = '0;
        if (!bus.user_r_read_32_open) begin
            w_state_nxt = StIdle;
`ifdef XLB_ARB_HDR_EN
            w_cont_nxt  = '0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_any_valid) begin
                        w_grant_nxt     = w_pick;
                        w_rr_ptr_nxt    = w_pick;
                        w_burst_cnt_nxt = '0;
`ifdef XLB_ARB_HDR_EN
                        w_state_nxt     = StHdr;
`else
                        w_state_nxt     = StData;
`endif
                    end
                end
                StHdr: begin
`ifdef XLB_ARB_HDR_EN
                    if (!w_full) begin
                        w_push          = 1'b1;
                        w_push_data     = {8'hA5, 8'(r_grant), r_cont[r_grant], 15'd0};
                        w_burst_cnt_nxt = '0;
                        w_state_nxt     = StData;
                    end
`else
                    w_state_nxt = StIdle;
`endif
                end
                StData: begin
                    w_ready[r_grant] = !w_full;
                    if (bus.req_valid[r_grant] && !w_full) begin
                        w_push          = 1'b1;
                        w_burst_cnt_nxt = r_burst_cnt + 16'd1;
                        if (bus.req_last[r_grant]) begin
`ifdef XLB_ARB_HDR_EN
                            w_cont_nxt[r_grant] = 1'b0;
`endif
                            w_state_nxt = StIdle;
                        end else if (w_burst_cnt_nxt == MaxBurstCnt) begin
                            // Burst cap: yield to other producers, packet continues later.
`ifdef XLB_ARB_HDR_EN
                            w_cont_nxt[r_grant] = 1'b1;
`endif
                            w_state_nxt = StIdle;
                        end
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    // Grant FSM state registers.
    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_rr_ptr    <= LastIdx;
            r_grant     <= '0;
            r_burst_cnt <= '0;
`ifdef XLB_ARB_HDR_EN
            r_cont      <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant     <= w_grant_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
`ifdef XLB_ARB_HDR_EN
            r_cont      <= w_cont_nxt;
`endif
        end
    end

    // FIFO pointers, occupancy and read-data register; closing the file flushes.
    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_data  <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PtrOne;
            if (w_pop) begin
                r_rptr <= r_rptr + PtrOne;
                r_data <= r_mem[r_rptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntOne;
                2'b01:   r_count <= r_count - CntOne;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge bus_clk) begin
        if (w_push) r_mem[r_wptr] <= w_push_data;
    end

    assign bus.user_r_read_32_data  = r_data;
    assign bus.user_r_read_32_empty = w_empty;
    assign bus.user_r_read_32_eof   = 1'b0;
    assign bus.req_ready            = w_ready;
endmodule

// File: tb/tb_xillybus_rr_stream_arbiter.sv
// Self-checking bench for xillybus_rr_stream_arbiter (N_REQ=4, 4-deep FIFO, MAX_BURST=4).
// Follows XLB_ARB_HDR_EN: header words are expected only when it is defined.
module tb_xillybus_rr_stream_arbiter;
    localparam int unsigned NReq     = 4;
    localparam int unsigned MaxBurst = 4;
`ifdef XLB_ARB_HDR_EN
    localparam bit HdrEn = 1'b1;
`else
    localparam bit HdrEn = 1'b0;
`endif

    logic bus_clk = 1'b0;
    logic reset;
    always #5 bus_clk = ~bus_clk;

    xillybus_rr_stream_arbiter_if #(.N_REQ(NReq)) bus ();

    xillybus_rr_stream_arbiter #(
        .N_REQ      (NReq),
        .DEPTH_LOG2 (2),
        .MAX_BURST  (MaxBurst)
    ) dut (
        .bus_clk (bus_clk),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct {
        int unsigned       src;
        int unsigned       n_words;
        logic [0:7][31:0]  words;
        logic [7:0]        last_mask;
        int unsigned       n_exp;
        logic [0:11][31:0] exp;
    } vec_t;

    vec_t vecs [5];

    int n_cmp = 0;
    int n_fail = 0;
    logic [32:0]  pq [NReq][$];   // {last, data} per producer
    int unsigned  pidx [NReq];
    logic [31:0]  rx [$];
    logic [31:0]  exp_q [$];
    bit           rden_en, rden_rand;
    int unsigned  acc_total, cyc, first_acc;
    logic [NReq-1:0] ready_seen;
    int unsigned  m_rr;
    bit           m_cont [NReq];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    // Header words vanish from the expected stream when headers are not built in.
    function automatic void exp_push(input logic [31:0] w);
        if (HdrEn || w[31:24] != 8'hA5) exp_q.push_back(w);
    endfunction

    task automatic drive();
        logic [32:0] e;
        for (int i = 0; i < NReq; i++) begin
            if (pidx[i] < pq[i].size()) begin
                e = pq[i][pidx[i]];
                bus.req_valid[i]         = 1'b1;
                bus.req_data[32*i +: 32] = e[31:0];
                bus.req_last[i]          = e[32];
            end else begin
                bus.req_valid[i]         = 1'b0;
                bus.req_data[32*i +: 32] = 32'h0;
                bus.req_last[i]          = 1'b0;
            end
        end
        bus.user_r_read_32_rden = rden_en && (!rden_rand || ($urandom_range(0, 99) < 60));
    endtask

    // One clock: handshakes sampled mid-cycle, effects observed 1 after the edge.
    task automatic step();
        logic [NReq-1:0] acc;
        logic pop;
        @(negedge bus_clk);
        acc = bus.req_valid & bus.req_ready;
        pop = bus.user_r_read_32_rden && !bus.user_r_read_32_empty && bus.user_r_read_32_open;
        ready_seen |= bus.req_ready;
        n_cmp++;
        if (!$onehot0(bus.req_ready)) begin
            n_fail++;
            $display("FAIL ready_onehot: got %b, required at most one bit", bus.req_ready);
        end
        @(posedge bus_clk);
        #1;
        cyc++;
        for (int i = 0; i < NReq; i++) begin
            if (acc[i]) begin
                pidx[i]++;
                acc_total++;
            end
        end
        if (acc != '0 && first_acc == 0) first_acc = cyc;
        if (pop) rx.push_back(bus.user_r_read_32_data);
        drive();
    endtask

    task automatic run_until(input int unsigned n, input int unsigned budget, input string tag);
        int unsigned c = 0;
        while (rx.size() < n && c < budget) begin
            step();
            c++;
        end
        for (int k = 0; k < 6; k++) step();
        check({tag, "_word_count"}, rx.size(), n);
    endtask

    function automatic void check_rx(input string tag);
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (k >= rx.size()) begin
                n_fail++;
                $display("FAIL %s_word%0d: got nothing, required %h", tag, k, exp_q[k]);
            end else if (rx[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL %s_word%0d: got %h, required %h", tag, k, rx[k], exp_q[k]);
            end
        end
    endfunction

    // Transaction-level reference: serve queued packets round-robin, MaxBurst words per
    // grant, assuming every producer holding words presents them continuously.
    function automatic void build_expected();
        int unsigned pos [NReq];
        int          pick;
        int unsigned n;
        logic [32:0] w;
        bit          done;
        exp_q.delete();
        for (int i = 0; i < NReq; i++) pos[i] = pidx[i];
        while (1) begin
            pick = -1;
            for (int k = 1; k <= NReq; k++) begin
                int c = int'((m_rr + k) % NReq);
                if (pick < 0 && pos[c] < pq[c].size()) pick = c;
            end
            if (pick < 0) break;
            m_rr = pick;
            exp_push({8'hA5, 8'(pick), m_cont[pick], 15'h0});
            n = 0;
            done = 0;
            while (!done) begin
                w = pq[pick][pos[pick]];
                pos[pick]++;
                n++;
                exp_q.push_back(w[31:0]);
                if (w[32]) begin
                    m_cont[pick] = 0;
                    done = 1;
                end else if (n == MaxBurst) begin
                    m_cont[pick] = 1;
                    done = 1;
                end else if (pos[pick] >= pq[pick].size()) begin
                    done = 1;
                end
            end
        end
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 3, {32'h11, 32'h22, 32'h33, {5{32'h0}}}, 8'h04, 4,
                    {32'hA500_0000, 32'h11, 32'h22, 32'h33, {8{32'h0}}}};
        vecs[1] = '{1, 6, {32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, {2{32'h0}}},
                    8'h20, 8, {32'hA501_0000, 32'h101, 32'h102, 32'h103, 32'h104,
                    32'hA501_8000, 32'h105, 32'h106, {4{32'h0}}}};
        vecs[2] = '{3, 4, {32'h301, 32'h302, 32'h303, 32'h304, {4{32'h0}}}, 8'h08, 5,
                    {32'hA503_0000, 32'h301, 32'h302, 32'h303, 32'h304, {7{32'h0}}}};
        vecs[3] = '{3, 1, {32'h311, {7{32'h0}}}, 8'h01, 2,
                    {32'hA503_0000, 32'h311, {10{32'h0}}}};
        vecs[4] = '{2, 5, {32'h201, 32'h202, 32'h203, 32'h204, 32'h205, {3{32'h0}}}, 8'h12, 7,
                    {32'hA502_0000, 32'h201, 32'h202, 32'hA502_0000, 32'h203, 32'h204,
                    32'h205, {5{32'h0}}}};

        // Reset values
        reset = 1'b1;
        bus.user_r_read_32_open = 1'b1;
        rden_en = 1'b0;
        rden_rand = 1'b0;
        ready_seen = '0;
        drive();
        repeat (3) @(posedge bus_clk);
        #1;
        check("rst_data", bus.user_r_read_32_data, 32'h0);
        check("rst_empty", 32'(bus.user_r_read_32_empty), 32'h1);
        check("rst_eof", 32'(bus.user_r_read_32_eof), 32'h0);
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        reset = 1'b0;
        step();
        step();
        check("idle_empty", 32'(bus.user_r_read_32_empty), 32'h1);

        // Directed vectors: single producers, burst cap, last exactly at cap, two packets
        for (int v = 0; v < 5; v++) begin
            rx.delete();
            exp_q.delete();
            acc_total = 0;
            cyc = 0;
            first_acc = 0;
            for (int j = 0; j < vecs[v].n_words; j++)
                pq[vecs[v].src].push_back({vecs[v].last_mask[j], vecs[v].words[j]});
            for (int j = 0; j < vecs[v].n_exp; j++) exp_push(vecs[v].exp[j]);
            rden_en = 1'b1;
            drive();
            run_until(exp_q.size(), 200, $sformatf("vec%0d", v));
            check_rx($sformatf("vec%0d", v));
            // Valid rises in IDLE; the first data accept lands one cycle later per header.
            check($sformatf("vec%0d_first_accept_cycle", v), first_acc, HdrEn ? 3 : 2);
        end

        // Producers 0 and 2 both busy with 1-word packets: strict alternation
        rx.delete();
        exp_q.delete();
        ready_seen = '0;
        for (int k = 0; k < 4; k++) begin
            pq[0].push_back({1'b1, 32'(32'h100 + k)});
            pq[2].push_back({1'b1, 32'(32'h200 + k)});
            exp_push(32'hA500_0000);
            exp_push(32'(32'h100 + k));
            exp_push(32'hA502_0000);
            exp_push(32'(32'h200 + k));
        end
        drive();
        run_until(exp_q.size(), 300, "alt");
        check_rx("alt");
        check("alt_p1_never_ready", 32'(ready_seen[1]), 32'h0);

        // FIFO full with rden held low, then a single pop frees exactly one slot
        rx.delete();
        exp_q.delete();
        acc_total = 0;
        rden_en = 1'b0;
        for (int k = 1; k <= 8; k++) pq[0].push_back({k == 8, 32'(32'h400 + k)});
        exp_push(32'hA500_0000);
        for (int k = 1; k <= 4; k++) exp_push(32'(32'h400 + k));
        exp_push(32'hA500_8000);
        for (int k = 5; k <= 8; k++) exp_push(32'(32'h400 + k));
        drive();
        repeat (12) step();
        check("full_accepts", acc_total, HdrEn ? 3 : 4);
        check("full_ready", 32'(bus.req_ready), 32'h0);
        check("full_not_empty", 32'(bus.user_r_read_32_empty), 32'h0);
        rden_en = 1'b1;
        drive();
        step();
        rden_en = 1'b0;
        drive();
        repeat (6) step();
        check("one_pop_one_accept", acc_total, HdrEn ? 4 : 5);
        rden_en = 1'b1;
        drive();
        run_until(exp_q.size(), 100, "full");
        check_rx("full");

        // Close mid-packet after two words, then reopen
        rx.delete();
        exp_q.delete();
        acc_total = 0;
        rden_en = 1'b0;
        for (int k = 1; k <= 5; k++) pq[1].push_back({k == 5, 32'(32'h500 + k)});
        drive();
        for (int g = 0; g < 20 && acc_total < 2; g++) step();
        check("close_accepts_before", acc_total, 2);
        bus.user_r_read_32_open = 1'b0;
        #1;
        check("close_ready", 32'(bus.req_ready), 32'h0);
        step();
        check("close_empty", 32'(bus.user_r_read_32_empty), 32'h1);
        repeat (3) step();
        check("close_no_accept", acc_total, 2);
        bus.user_r_read_32_open = 1'b1;
        rden_en = 1'b1;
        exp_push(32'hA501_0000);
        for (int k = 3; k <= 5; k++) exp_push(32'(32'h500 + k));
        drive();
        run_until(exp_q.size(), 100, "reopen");
        check_rx("reopen");

        // Reset mid-burst returns outputs to reset values at once
        rx.delete();
        for (int k = 1; k <= 6; k++) pq[2].push_back({k == 6, 32'(32'h600 + k)});
        drive();
        for (int g = 0; g < 30 && rx.size() < 2; g++) step();
        check("mid_rst_words_seen", rx.size(), 2);
        reset = 1'b1;
        #1;
        check("mid_rst_data", bus.user_r_read_32_data, 32'h0);
        check("mid_rst_empty", 32'(bus.user_r_read_32_empty), 32'h1);
        check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        for (int i = 0; i < NReq; i++) begin
            pq[i].delete();
            pidx[i] = 0;
            m_cont[i] = 0;
        end
        m_rr = NReq - 1;
        drive();
        step();
        step();
        reset = 1'b0;

        // Randomised packets and host pacing against the transaction-level model
        for (int r = 0; r < 6; r++) begin
            rx.delete();
            for (int i = 0; i < NReq; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    int unsigned np = $urandom_range(1, 3);
                    for (int p = 0; p < np; p++) begin
                        int unsigned len = $urandom_range(1, 7);
                        for (int j = 0; j < len; j++) pq[i].push_back({j == len - 1, $urandom()});
                    end
                end
            end
            build_expected();
            rden_en = 1'b1;
            rden_rand = 1'b1;
            drive();
            run_until(exp_q.size(), 2000, $sformatf("rand%0d", r));
            check_rx($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
